// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, ACK check, one data byte, STOP.
// scl and the sda pull-down are registered from the next-state decode so the bus never glitches.
module i2c_master_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK1,
        S_DATA,
        S_ACK2,
        S_STOP
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [1:0]       q, q_n;
    logic [2:0]       bit_idx, bit_n;
    logic [6:0]       addr_r;
    logic             rw_r;
    logic [7:0]       wdata_r;
    logic [7:0]       shadow;
    logic [7:0]       frame;
    logic             sda_low;
    logic             scl_n, low_n, done_n, accept;
    logic             tick, bit_end, sample;

    assign sda     = sda_low ? 1'b0 : 1'bz;
    assign frame   = {addr_r, rw_r};
    assign tick    = (div_cnt == DIV_LAST);
    assign bit_end = tick && (q == 2'd3);
    // sda has been stable since the start of q0, so it is sampled on the first clk of q2.
    assign sample  = (q == 2'd2) && (div_cnt == '0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n = state;
        div_n   = tick ? '0 : div_cnt + 1'b1;
        q_n     = q;
        bit_n   = bit_idx;
        done_n  = 1'b0;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                div_n = '0;
                q_n   = '0;
                bit_n = '0;
                // A start landing on the done cycle is dropped; the next cycle may start again.
                if (start && !done) begin
                    accept  = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd1) begin
                        q_n     = '0;
                        state_n = S_ADDR;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (tick) q_n = q + 2'd1;
                if (bit_end) begin
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = (state == S_ADDR) ? S_ACK1 : S_ACK2;
                end
            end
            S_ACK1: begin
                if (tick) q_n = q + 2'd1;
                if (bit_end) state_n = ack_err ? S_STOP : S_DATA;
            end
            S_ACK2: begin
                if (tick) q_n = q + 2'd1;
                if (bit_end) state_n = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd2) begin
                        q_n     = '0;
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bus levels for the upcoming cycle, decoded from the next state.
    always_comb begin
        scl_n = 1'b1;
        low_n = 1'b0;
        case (state_n)
            S_START: low_n = (q_n == 2'd1);
            S_ADDR: begin
                scl_n = q_n[1];
                low_n = !frame[3'd7 - bit_n];
            end
            S_DATA: begin
                scl_n = q_n[1];
                low_n = !rw_r && !wdata_r[3'd7 - bit_n];
            end
            S_ACK1, S_ACK2: scl_n = q_n[1];
            S_STOP: begin
                scl_n = (q_n != 2'd0);
                low_n = (q_n != 2'd2);
            end
            default: begin
                scl_n = 1'b1;
                low_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            q       <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
            scl     <= 1'b1;
            sda_low <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state   <= state_n;
            div_cnt <= div_n;
            q       <= q_n;
            bit_idx <= bit_n;
            busy    <= (state_n != S_IDLE);
            done    <= done_n;
            scl     <= scl_n;
            sda_low <= low_n;
            if (accept) ack_err <= 1'b0;
            else if (state == S_ACK1 && sample) ack_err <= sda;
            if (state == S_ACK2 && bit_end && rw_r) rdata <= shadow;
        end
    end

    // NOTE: the captured request and the shift register have no reset; each is loaded before it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_r  <= addr;
            rw_r    <= rw;
            wdata_r <= wdata;
        end
        if (state == S_DATA && rw_r && sample) shadow <= {shadow[6:0], sda};
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: directed transactions against a fixed-address slave model,
// a done-triggered scoreboard, and a bus monitor checking START/STOP placement and timing.
module tb_i2c_master_byte;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic       rw = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl;
    wire        sda;
    logic       slave_low = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .addr   (addr),
        .rw     (rw),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .ack_err(ack_err),
        .scl    (scl),
        .sda    (sda)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          latency;
        logic [7:0]  rdata;
        logic        ack_err;
        int          nbits;
        logic [31:0] seq;
        logic        chk_data;
        logic [7:0]  data_in;
        int          accept_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    function automatic exp_t mk(input int lat, input logic [7:0] rd, input logic ae, input int nb,
                                input logic [31:0] sq, input logic cd, input logic [7:0] di);
        exp_t e;
        e.latency    = lat;
        e.rdata      = rd;
        e.ack_err    = ae;
        e.nbits      = nb;
        e.seq        = sq;
        e.chk_data   = cd;
        e.data_in    = di;
        e.accept_cyc = 0;
        return e;
    endfunction

    // Bus monitor + slave at address 7'h78; samples at negedge, drives sda after scl falls.
    logic        prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0;
    int          mbits = 0, start_cyc = 0, rise_cyc = 0, frame_bits = 0;
    logic [31:0] mseq = '0, frame_seq = '0;
    logic        slv_sel = 1'b0, slv_rw = 1'b0;
    logic [7:0]  slv_rbyte = 8'hCD, slv_data_in = '0;

    always @(negedge clk) begin
        logic sda_v;
        sda_v = sda;
        if (rst) begin
            in_frame  = 1'b0;
            mbits     = 0;
            mseq      = '0;
            slv_sel   = 1'b0;
            slave_low <= 1'b0;
        end else begin
            if (scl && prev_scl && sda_v != prev_sda) begin
                if (!sda_v) begin
                    check1("start_outside_frame", in_frame, 1'b0);
                    in_frame    = 1'b1;
                    mbits       = 0;
                    mseq        = '0;
                    slv_data_in = '0;
                    start_cyc   = cyc;
                end else begin
                    check1("stop_inside_frame", in_frame, 1'b1);
                    check1("stop_setup_ge_div", (cyc - rise_cyc) >= CLK_DIV, 1'b1);
                    in_frame   = 1'b0;
                    frame_bits = mbits - 1;
                    frame_seq  = mseq >> 1;
                end
            end
            if (scl && !prev_scl) begin
                rise_cyc = cyc;
                if (in_frame) begin
                    mseq  = {mseq[30:0], sda_v};
                    mbits = mbits + 1;
                end
            end
            if (!scl && prev_scl && in_frame) begin
                if (mbits == 0) check1("start_hold_ge_div", (cyc - start_cyc) >= CLK_DIV, 1'b1);
                if (mbits == 8) begin
                    slv_sel = (mseq[7:1] == 7'h78);
                    slv_rw  = mseq[0];
                    slave_low <= slv_sel;
                end else if (mbits >= 9 && mbits <= 16) begin
                    slave_low <= slv_sel && slv_rw && !slv_rbyte[16 - mbits];
                end else if (mbits == 17) begin
                    if (slv_sel && !slv_rw) slv_data_in = mseq[7:0];
                    slave_low <= slv_sel && !slv_rw;
                end else begin
                    slave_low <= 1'b0;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda_v;
    end

    // Scoreboard monitor: every done pulse pops one expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulsed with nothing pending at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - e.accept_cyc, e.latency);
                check("rdata", 32'(rdata), 32'(e.rdata));
                check1("ack_err", ack_err, e.ack_err);
                check1("busy_low_at_done", busy, 1'b0);
                check("frame_bits", frame_bits, e.nbits);
                check("frame_seq", frame_seq, e.seq);
                if (e.chk_data) check("slave_data_in", 32'(slv_data_in), 32'(e.data_in));
            end
        end
    end

    task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] w, input bit push, input exp_t e);
        exp_t x;
        x = e;
        @(negedge clk);
        addr  = a;
        rw    = r;
        wdata = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x.accept_cyc = cyc;
        check1("busy_after_accept", busy, 1'b1);
        check1("ack_err_cleared", ack_err, 1'b0);
        if (push) sb.push_back(x);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
        check1({name, "_done_seen"}, done, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   base;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_scl", scl, 1'b1);
        check1("reset_sda", sda, 1'b1);
        check("reset_rdata", 32'(rdata), 32'h00);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check1("reset_ack_err", ack_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        launch(7'h78, 1'b0, 8'hA5, 1'b1,
               mk(308, 8'h00, 1'b0, 18, 32'({7'h78, 1'b0, 1'b0, 8'hA5, 1'b0}), 1'b1, 8'hA5));
        wait_done("write");

        launch(7'h78, 1'b1, 8'h00, 1'b1,
               mk(308, 8'hCD, 1'b0, 18, 32'({7'h78, 1'b1, 1'b0, 8'hCD, 1'b1}), 1'b0, 8'h00));
        wait_done("read");

        launch(7'h12, 1'b0, 8'h33, 1'b1,
               mk(164, 8'hCD, 1'b1, 9, 32'({7'h12, 1'b0, 1'b1}), 1'b0, 8'h00));
        wait_done("addr_nack");

        // Reset in q0 of address bit 3 (cycles 56..59 after accept).
        launch(7'h78, 1'b0, 8'h5A, 1'b0, mk(0, 8'h00, 1'b0, 0, 32'h0, 1'b0, 8'h00));
        repeat (57) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check1("midreset_scl", scl, 1'b1);
        check1("midreset_sda", sda, 1'b1);
        check1("midreset_busy", busy, 1'b0);
        check("midreset_rdata", 32'(rdata), 32'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = done_count;
        repeat (400) @(negedge clk);
        check("midreset_no_done", done_count, base);
        check1("midreset_idle_busy", busy, 1'b0);

        launch(7'h78, 1'b0, 8'h0F, 1'b1,
               mk(308, 8'h00, 1'b0, 18, 32'({7'h78, 1'b0, 1'b0, 8'h0F, 1'b0}), 1'b1, 8'h0F));
        repeat (100) @(negedge clk);
        addr  = 7'h12;
        rw    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1("busy_through_ignored_start", busy, 1'b1);
        wait_done("write_after_reset");

        // Still in the done cycle: this start must be ignored, then accepted one cycle later.
        slv_rbyte = 8'h3C;
        addr  = 7'h78;
        rw    = 1'b1;
        wdata = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        check1("start_on_done_ignored", busy, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check1("start_after_done_accepted", busy, 1'b1);
        e = mk(308, 8'h3C, 1'b0, 18, 32'({7'h78, 1'b1, 1'b0, 8'h3C, 1'b1}), 1'b0, 8'h00);
        e.accept_cyc = cyc;
        sb.push_back(e);
        wait_done("read_after_done");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Single-byte I2C master. Sits directly upstream of the fixed-address I2C slave (address 7'b1111000) on the same scl/sda pair.
- Converts a one-cycle start request on the system clock into a complete bus transaction: START, 7-bit address + R/W, ACK check, one data byte written or read, STOP.
- Reports completion, address-NACK and the read byte back to the system side.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period; legal range >= 2. One SCL bit = 4*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only when busy=0
addr  input  7  target slave address, captured on accepted start
rw  input  1  1=read, 0=write, captured on accepted start
wdata  input  8  byte to write, captured on accepted start
rdata  output  8  byte received on read, MSB first; holds until next read completes
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when STOP completes
ack_err  output  1  1 = address phase NACKed; valid with done, holds until next accepted start
scl  output  1  push-pull SCL; no clock stretching
sda  inout  1  open-drain: driven 0 or high-Z only; external pull-up

Behaviour:
- Reset values: scl=1, sda=Z, rdata=0, busy=0, done=0, ack_err=0, state=IDLE.
- Reset mid-operation: on the next posedge, scl=1, sda=Z and busy=0. No done pulse. No STOP is generated.
- Quarter counter q (0..3) advances every CLK_DIV clk cycles.
- Data bits: scl=0 in q0-q1 and scl=1 in q2-q3. sda changes only at the start of q0. The master samples sda on the first clk of q2.
- States and durations:
  - IDLE: scl=1, sda=Z. An accepted start captures addr, rw and wdata, clears ack_err, and enters START.
  - START (2 quarters): Q-a sda=Z, scl=1; Q-b sda=0, scl=1.
  - ADDR (8 bits): addr[6] down to addr[0], then rw. Bit 1 → sda=Z, bit 0 → sda=0.
  - ACK1 (1 bit): sda=Z; sample in q2.
    - Sampled 0 → DATA.
    - Sampled 1 → ack_err=1, go to STOP. No data bits are issued.
  - DATA (8 bits):
    - Write: drive wdata[7] down to wdata[0].
    - Read: sda=Z; shift sampled bits into a shadow register, MSB first.
  - ACK2 (1 bit):
    - Write: sda=Z; the slave ACK is sampled but ignored (not reported).
    - Read: master sends NACK (sda=Z), then rdata <= shadow register.
  - STOP (3 quarters): S-a scl=0, sda=0; S-b scl=1, sda=0; S-c scl=1, sda=Z.
  - After STOP: done=1 for one cycle, busy=0, return to IDLE.
- Latency from the start-accept cycle to done:
  - Full transaction: 77*CLK_DIV cycles (2 + 18*4 + 3 quarters).
  - Address-NACK transaction: 41*CLK_DIV cycles (2 + 9*4 + 3 quarters).
- sda never changes while scl=1, except the START and STOP edges.
- start while busy=1 is ignored; no queuing. start in the same cycle as done is ignored. start is accepted from the following cycle.
- rdata is unchanged by write transactions and by address-NACK transactions.

Test Plan:
- Write: start with addr=7'h78, rw=0, wdata=8'hA5, CLK_DIV=4, slave model on bus → ack_err=0; done exactly 308 cycles after accept; slave data_in=8'hA5; sda bit sequence observed at scl rises is 1111000,0,ACK,10100101.
- Read: addr=7'h78, rw=1 → slave returns 8'hCD. Required: rdata=8'hCD at done, ack_err=0, master NACK on bit 18, done at cycle 308.
- Wrong address: addr=7'h12 → ack_err=1; done at cycle 164; no scl pulses after the ACK1 bit other than STOP; rdata unchanged.
- Reset mid-ADDR (during bit 3): the cycle after rst → scl=1, sda=Z, busy=0, done never pulses; a new start then completes normally.
- start pulses during busy and on the done cycle are ignored. A start one cycle after done is accepted, and busy rises the next cycle.
- Bus checker across all tests: sda never transitions while scl=1 except the START falling edge and the STOP rising edge; START hold and STOP setup are each >= CLK_DIV cycles.
